// File: rtl/sr_drv_pkg.sv
// Shared types and helpers for the SR latch command driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, op encoding, timer load selector, counter-width helper.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Op encoding doubles as the value the latch holds after the command.
  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  // Phase timer load selector.
  localparam logic SEL_PULSE = 1'b0;
  localparam logic SEL_GAP   = 1'b1;

  // Width needed to hold the larger of the two phase lengths.
  function automatic int cnt_width(input int pulse_cyc, input int gap_cyc);
    int mx;
    mx = (pulse_cyc > gap_cyc) ? pulse_cyc : gap_cyc;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter timing the PULSE and GAP phases; done marks the final cycle of a phase.
// Latency: load takes effect next cycle; done is high during the last counted cycle.
// Backpressure: none; load always wins over counting.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   load        : restart the count this edge
//   load_sel    : SEL_PULSE loads PULSE_CYC, SEL_GAP loads GAP_CYC
//   done        : current cycle is the last one of the loaded phase
module sr_phase_timer
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1,
  parameter int W         = cnt_width(PULSE_CYC, GAP_CYC)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic load_sel,
  output logic done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_sel == SEL_GAP) ? W'(GAP_CYC) : W'(PULSE_CYC);
    end else if (cnt_q != '0) begin
      // Saturate at zero so an idle timer never raises done again.
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/sr_latch_driver.sv
// Turns one-cycle set/clear requests into timed s/r/en sequences for an SR latch, with a one-deep pending slot.
// Latency: request in cycle N drives s/r with en at N+1 when idle; latch_q updates on the first GAP cycle.
// Backpressure: req_ready low while the slot is full or during INIT; refused requests pulse drop, both-high pulses conflict.
//
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   set_req, clr_req   : one-cycle command requests (exactly one high = valid)
//   req_ready          : a single request presented this cycle is accepted
//   busy               : PULSE or GAP in progress
//   s, r, en, lrst     : latch drive (s and r never high together)
//   latch_q            : expected latch output
//   conflict, drop     : one-cycle status pulses
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  output logic req_ready,
  output logic busy,
  output logic s,
  output logic r,
  output logic en,
  output logic lrst,
  output logic latch_q,
  output logic conflict,
  output logic drop
);

  state_t state_q, state_d;
  logic   op_q, op_d;
  logic   pend_vld_q, pend_vld_d;
  logic   pend_op_q, pend_op_d;
  logic   lat_q, lat_d;
  logic   s_q, s_d;
  logic   r_q, r_d;
  logic   en_q, en_d;
  logic   lrst_q, lrst_d;
  logic   busy_q, busy_d;
  logic   rdy_q, rdy_d;
  logic   conflict_q, conflict_d;
  logic   drop_q, drop_d;

  logic   req_vld;
  logic   req_both;
  logic   req_op;
  logic   accept;
  logic   tmr_load;
  logic   tmr_sel;
  logic   tmr_done;

  sr_phase_timer #(
    .PULSE_CYC (PULSE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_sel (tmr_sel),
    .done     (tmr_done)
  );

  assign req_vld  = set_req ^ clr_req;
  assign req_both = set_req & clr_req;
  assign req_op   = set_req ? OP_SET : OP_CLR;
  // rdy_q is exactly the registered view of "IDLE, or PULSE/GAP with empty slot".
  assign accept   = req_vld & rdy_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pend_vld_d = pend_vld_q;
    pend_op_d  = pend_op_q;
    lat_d      = lat_q;
    tmr_load   = 1'b0;
    tmr_sel    = SEL_PULSE;

    case (state_q)
      INIT: begin
        state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          state_d  = PULSE;
          op_d     = req_op;
          tmr_load = 1'b1;
          tmr_sel  = SEL_PULSE;
        end
      end
      PULSE: begin
        if (accept) begin
          pend_vld_d = 1'b1;
          pend_op_d  = req_op;
        end
        if (tmr_done) begin
          state_d  = GAP;
          lat_d    = op_q;
          tmr_load = 1'b1;
          tmr_sel  = SEL_GAP;
        end
      end
      GAP: begin
        if (tmr_done) begin
          if (pend_vld_q) begin
            // Queued command wins; any new request here was already refused (rdy_q=0).
            state_d    = PULSE;
            op_d       = pend_op_q;
            pend_vld_d = 1'b0;
            tmr_load   = 1'b1;
            tmr_sel    = SEL_PULSE;
          end else if (accept) begin
            state_d  = PULSE;
            op_d     = req_op;
            tmr_load = 1'b1;
            tmr_sel  = SEL_PULSE;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          pend_vld_d = 1'b1;
          pend_op_d  = req_op;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase

    // Outputs decoded from next state so they come straight off flops.
    en_d       = (state_d == PULSE);
    s_d        = (state_d == PULSE) && (op_d == OP_SET);
    r_d        = (state_d == PULSE) && (op_d == OP_CLR);
    lrst_d     = (state_d == INIT);
    busy_d     = (state_d == PULSE) || (state_d == GAP);
    rdy_d      = (state_d == IDLE) ||
                 (((state_d == PULSE) || (state_d == GAP)) && !pend_vld_d);
    conflict_d = req_both;
    drop_d     = req_vld & ~rdy_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      op_q       <= OP_CLR;
      pend_vld_q <= 1'b0;
      pend_op_q  <= OP_CLR;
      lat_q      <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      en_q       <= 1'b0;
      lrst_q     <= 1'b1;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b0;
      conflict_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      pend_vld_q <= pend_vld_d;
      pend_op_q  <= pend_op_d;
      lat_q      <= lat_d;
      s_q        <= s_d;
      r_q        <= r_d;
      en_q       <= en_d;
      lrst_q     <= lrst_d;
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
      conflict_q <= conflict_d;
      drop_q     <= drop_d;
    end
  end

  assign req_ready = rdy_q;
  assign busy      = busy_q;
  assign s         = s_q;
  assign r         = r_q;
  assign en        = en_q;
  assign lrst      = lrst_q;
  assign latch_q   = lat_q;
  assign conflict  = conflict_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: timeline model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_sr_latch_driver;

  localparam int P = 2;
  localparam int G = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic req_ready, busy, s, r, en, lrst, latch_q, conflict, drop;

  int n_pass = 0;
  int n_chk  = 0;

  // Model: every accepted command becomes one scheduled sequence occupying
  // cycles [start, start+P+G); outputs at cycle t are read off that timeline.
  int   seq_start[$];
  logic seq_op[$];
  int   t_cyc = -1;
  logic prev_vld  = 1'b0;
  logic prev_rdy  = 1'b0;
  logic prev_both = 1'b0;

  sr_latch_driver #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_req   (set_req),
    .clr_req   (clr_req),
    .req_ready (req_ready),
    .busy      (busy),
    .s         (s),
    .r         (r),
    .en        (en),
    .lrst      (lrst),
    .latch_q   (latch_q),
    .conflict  (conflict),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit pending_at(input int t);
    foreach (seq_start[i]) if (seq_start[i] > t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void expect_at(input int t,
      output logic e_s, output logic e_r, output logic e_en, output logic e_busy,
      output logic e_lat);
    int st;
    e_s = 0; e_r = 0; e_en = 0; e_busy = 0; e_lat = 0;
    foreach (seq_start[i]) begin
      st = seq_start[i];
      if (t >= st && t < st + P) begin
        e_en = 1'b1;
        if (seq_op[i]) e_s = 1'b1; else e_r = 1'b1;
      end
      if (t >= st && t < st + P + G) e_busy = 1'b1;
      if (t >= st + P) e_lat = seq_op[i];
    end
  endfunction

  task automatic model_step();
    logic e_s, e_r, e_en, e_busy, e_lat, e_rdy, e_lrst, e_cf, e_dp, vld;
    int nstart, last_end;
    string c;
    e_s = 0; e_r = 0; e_en = 0; e_busy = 0; e_lat = 0;
    e_rdy = 0; e_lrst = 1; e_cf = 0; e_dp = 0;
    if (!rst_n) begin
      seq_start.delete();
      seq_op.delete();
      prev_vld = 0; prev_rdy = 0; prev_both = 0;
      t_cyc = -1;
      c = "rst";
    end else begin
      expect_at(t_cyc, e_s, e_r, e_en, e_busy, e_lat);
      e_lrst = (t_cyc == -1);
      e_rdy  = (t_cyc >= 0) && !pending_at(t_cyc);
      e_cf   = prev_both;
      e_dp   = prev_vld & ~prev_rdy;
      c = $sformatf("cyc%0d", t_cyc);
    end
    chk({"model s ", c}, s, e_s);
    chk({"model r ", c}, r, e_r);
    chk({"model en ", c}, en, e_en);
    chk({"model busy ", c}, busy, e_busy);
    chk({"model latch_q ", c}, latch_q, e_lat);
    chk({"model req_ready ", c}, req_ready, e_rdy);
    chk({"model lrst ", c}, lrst, e_lrst);
    chk({"model conflict ", c}, conflict, e_cf);
    chk({"model drop ", c}, drop, e_dp);
    if (!(s === 1'b1 && r === 1'b1)) n_pass++;
    else $display("FAIL s_and_r %s: got s=%b r=%b expected never both 1", c, s, r);
    n_chk++;
    if (rst_n) begin
      vld = set_req ^ clr_req;
      if (vld && e_rdy) begin
        nstart = t_cyc + 1;
        if (seq_start.size() > 0) begin
          last_end = seq_start[$] + P + G;
          if (last_end > nstart) nstart = last_end;
        end
        seq_start.push_back(nstart);
        seq_op.push_back(set_req);
      end
      prev_both = set_req & clr_req;
      prev_vld  = vld;
      prev_rdy  = e_rdy;
      t_cyc++;
    end
  endtask

  // Present inputs for the current cycle, then check at the falling edge.
  task automatic cyc(input logic sv, input logic cv);
    set_req = sv;
    clr_req = cv;
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of the INIT cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 0); adv();
    cyc(0, 0); adv();
    rst_n = 1'b1;
  endtask

  logic [1:0] burst [0:23];

  initial begin
    burst = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00,
              2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10,
              2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};

    // Reset release, INIT refuses requests.
    do_reset();
    cyc(1, 0);
    chk("init lrst", lrst, 1'b1);
    chk("init req_ready", req_ready, 1'b0);
    chk("init busy", busy, 1'b0);
    adv();
    cyc(0, 0);
    chk("c0 drop after INIT req", drop, 1'b1);
    chk("c0 lrst", lrst, 1'b0);
    chk("c0 req_ready", req_ready, 1'b1);
    chk("c0 latch_q", latch_q, 1'b0);
    adv();
    cyc(0, 0);
    chk("no pulse after INIT req", en, 1'b0);
    adv();

    // Single set.
    cyc(1, 0); adv();
    cyc(0, 0);
    chk("set p1 s", s, 1'b1); chk("set p1 en", en, 1'b1);
    chk("set p1 r", r, 1'b0); chk("set p1 busy", busy, 1'b1);
    adv();
    cyc(0, 0); chk("set p2 s", s, 1'b1); adv();
    cyc(0, 0);
    chk("set gap en", en, 1'b0); chk("set gap s", s, 1'b0);
    chk("set gap latch_q", latch_q, 1'b1); chk("set gap busy", busy, 1'b1);
    adv();
    cyc(0, 0);
    chk("set idle busy", busy, 1'b0); chk("set idle ready", req_ready, 1'b1);
    adv();

    // Conflict.
    cyc(1, 1); adv();
    cyc(0, 0);
    chk("conflict pulse", conflict, 1'b1); chk("conflict en", en, 1'b0);
    chk("conflict latch_q", latch_q, 1'b1); chk("conflict drop", drop, 1'b0);
    adv();
    cyc(0, 0);
    chk("conflict clears", conflict, 1'b0); chk("conflict busy", busy, 1'b0);
    adv();

    // set, queued clear, third request dropped.
    cyc(1, 0); adv();
    cyc(0, 1); chk("q s c1", s, 1'b1); adv();
    cyc(1, 0); chk("q ready full", req_ready, 1'b0); adv();
    cyc(0, 0);
    chk("q drop", drop, 1'b1); chk("q gap en", en, 1'b0);
    chk("q latch set", latch_q, 1'b1);
    adv();
    cyc(0, 0); chk("q r c4", r, 1'b1); chk("q en c4", en, 1'b1); chk("q s c4", s, 1'b0); adv();
    cyc(0, 0); chk("q r c5", r, 1'b1); adv();
    cyc(0, 0); chk("q gap2 en", en, 1'b0); chk("q latch clr", latch_q, 1'b0); adv();
    cyc(0, 0); chk("q idle busy", busy, 1'b0); adv();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0); chk("q third never runs", en, 1'b0); adv();
    end

    // Clear, then set presented in the last GAP cycle is taken directly.
    cyc(0, 1); adv();
    cyc(0, 0); adv();
    cyc(0, 0); adv();
    cyc(1, 0); chk("last gap ready", req_ready, 1'b1); chk("last gap en", en, 1'b0); adv();
    cyc(0, 0); chk("direct s", s, 1'b1); chk("direct busy", busy, 1'b1); adv();
    cyc(0, 0); adv();
    cyc(0, 0); chk("direct latch", latch_q, 1'b1); adv();
    cyc(0, 0); adv();

    // Redundant set with queued clear, reset mid-pulse.
    cyc(1, 0); adv();
    cyc(0, 1); chk("redundant s", s, 1'b1); adv();
    cyc(0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst s", s, 1'b0); chk("arst en", en, 1'b0);
    chk("arst lrst", lrst, 1'b1); chk("arst latch_q", latch_q, 1'b0);
    chk("arst busy", busy, 1'b0); chk("arst ready", req_ready, 1'b0);
    adv();
    cyc(0, 0); adv();
    rst_n = 1'b1;
    cyc(0, 0); chk("re-init lrst", lrst, 1'b1); adv();
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0);
      chk("lost clr r", r, 1'b0); chk("lost clr en", en, 1'b0);
      adv();
    end

    // Mixed burst, model-checked only.
    for (int i = 0; i < 24; i++) begin
      cyc(burst[i][1], burst[i][0]);
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
